// File: rtl/bpu_pkg.sv
// bpu_pkg: shared types, counter constants and saturating-counter helpers
// for the dynamic branch predictor.
//   CTR_WEAK_NT / CTR_WEAK_T / CTR_MAX : constants for the default 2-bit counter
//   ctr_weak_nt/ctr_weak_t/ctr_max()   : the same constants for any counter width
//   sat_step()                         : saturating +1 / -1, never wraps
//   bpu_entry_t                        : table entry {valid, tag, ctr, target}
//                                        at the default geometry
package bpu_pkg;

    // Widest counter the generic helpers handle.
    localparam int CTR_W_MAX = 8;

    localparam int DEF_BIT_WIDTH = 32;
    localparam int DEF_TAG_BITS  = 8;
    localparam int DEF_CTR_BITS  = 2;

    function automatic logic [CTR_W_MAX-1:0] ctr_weak_nt(input int bits);
        return CTR_W_MAX'((1 << (bits - 1)) - 1);
    endfunction

    function automatic logic [CTR_W_MAX-1:0] ctr_weak_t(input int bits);
        return CTR_W_MAX'(1 << (bits - 1));
    endfunction

    function automatic logic [CTR_W_MAX-1:0] ctr_max(input int bits);
        return CTR_W_MAX'((1 << bits) - 1);
    endfunction

    // Unsigned saturating step on a 'bits'-wide counter held in CTR_W_MAX bits.
    function automatic logic [CTR_W_MAX-1:0] sat_step(input logic [CTR_W_MAX-1:0] ctr,
                                                      input logic                 up,
                                                      input int                   bits);
        logic [CTR_W_MAX-1:0] top;
        top = ctr_max(bits);
        if (up)
            return (ctr == top) ? ctr : ctr + 1'b1;
        else
            return (ctr == '0) ? ctr : ctr - 1'b1;
    endfunction

    localparam logic [DEF_CTR_BITS-1:0] CTR_WEAK_NT = DEF_CTR_BITS'(ctr_weak_nt(DEF_CTR_BITS));
    localparam logic [DEF_CTR_BITS-1:0] CTR_WEAK_T  = DEF_CTR_BITS'(ctr_weak_t(DEF_CTR_BITS));
    localparam logic [DEF_CTR_BITS-1:0] CTR_MAX     = DEF_CTR_BITS'(ctr_max(DEF_CTR_BITS));

    typedef struct packed {
        logic                     valid;
        logic [DEF_TAG_BITS-1:0]  tag;
        logic [DEF_CTR_BITS-1:0]  ctr;
        logic [DEF_BIT_WIDTH-1:0] target;
    } bpu_entry_t;

endpackage

// File: rtl/bpu_sat_ctr.sv
// bpu_sat_ctr: next-state logic of one CTR_BITS-wide saturating counter.
//   ctr_cur  in   current counter value
//   up       in   1 = count toward taken, 0 = toward not-taken
//   ctr_nxt  out  saturated next value
module bpu_sat_ctr
    import bpu_pkg::*;
#(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr_cur,
    input  logic                up,
    output logic [CTR_BITS-1:0] ctr_nxt
);

    assign ctr_nxt = CTR_BITS'(sat_step(CTR_W_MAX'(ctr_cur), up, CTR_BITS));

endmodule

// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped tagged direction/target predictor.
// Lookup is combinational on if_pc; training comes from branches resolved in
// EX; a mispredict raises a one-cycle registered flush with redirect_pc.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   if_pc                            fetch PC to predict
//   pred_taken, pred_pc, pred_idx    prediction and table index used
//   upd_valid, upd_pc, upd_idx,      resolved branch: PC, fetch-time index,
//   upd_taken, upd_target,           actual direction/target, and what was
//   upd_pred_taken, upd_pred_pc      predicted for it at fetch
//   flush, redirect_pc               registered mispredict flush + correct PC
// Build option: define BPU_GSHARE_EN to XOR a global direction history into
// the lookup index (history is non-speculative, shifted on every upd_valid).
module branch_target_predictor
    import bpu_pkg::*;
#(
    parameter int BIT_WIDTH  = 32,
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8,
    parameter int CTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIT_WIDTH-1:0]  if_pc,
    output logic                  pred_taken,
    output logic [BIT_WIDTH-1:0]  pred_pc,
    output logic [INDEX_BITS-1:0] pred_idx,
    input  logic                  upd_valid,
    input  logic [BIT_WIDTH-1:0]  upd_pc,
    input  logic [INDEX_BITS-1:0] upd_idx,
    input  logic                  upd_taken,
    input  logic [BIT_WIDTH-1:0]  upd_target,
    input  logic                  upd_pred_taken,
    input  logic [BIT_WIDTH-1:0]  upd_pred_pc,
    output logic                  flush,
    output logic [BIT_WIDTH-1:0]  redirect_pc
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT  = CTR_BITS'(ctr_weak_nt(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_ALLOC = CTR_BITS'(ctr_weak_t(CTR_BITS));

    // Table state, one packed row per field.
    logic [ENTRIES-1:0]                valid_q, valid_d;
    logic [ENTRIES-1:0][TAG_BITS-1:0]  tag_q, tag_d;
    logic [ENTRIES-1:0][CTR_BITS-1:0]  ctr_q, ctr_d;
    logic [ENTRIES-1:0][BIT_WIDTH-1:0] target_q, target_d;

    logic                 flush_q, flush_d;
    logic [BIT_WIDTH-1:0] redirect_q, redirect_d;

    // ---------------- lookup ----------------
    logic [INDEX_BITS-1:0] base_idx, lk_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic                  lk_hit;

    assign base_idx = if_pc[INDEX_BITS+1:2];
    assign lk_tag   = if_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

`ifdef BPU_GSHARE_EN
    logic [INDEX_BITS-1:0] hist_q, hist_d;
    assign lk_idx = base_idx ^ hist_q;
    // Newest outcome enters at the LSB.
    assign hist_d = upd_valid ? ((hist_q << 1) | INDEX_BITS'(upd_taken)) : hist_q;
`else
    assign lk_idx = base_idx;
`endif

    assign lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken = lk_hit && ctr_q[lk_idx][CTR_BITS-1];
    assign pred_pc    = pred_taken ? target_q[lk_idx] : if_pc + BIT_WIDTH'(4);
    assign pred_idx   = lk_idx;

    // ---------------- update ----------------
    logic [TAG_BITS-1:0]  upd_tag;
    logic                 upd_hit;
    logic [CTR_BITS-1:0]  upd_ctr_nxt;
    logic [BIT_WIDTH-1:0] actual_npc;
    logic                 mispredict;

    assign upd_tag = upd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    bpu_sat_ctr #(.CTR_BITS(CTR_BITS)) u_sat_ctr (
        .ctr_cur (ctr_q[upd_idx]),
        .up      (upd_taken),
        .ctr_nxt (upd_ctr_nxt)
    );

    // Comparing the whole next PC catches direction and target errors alike;
    // the fetch-time direction is implied by upd_pred_pc.
    assign actual_npc = upd_taken ? upd_target : upd_pc + BIT_WIDTH'(4);
    assign mispredict = upd_valid && (actual_npc != upd_pred_pc);

    logic unused_pred_taken;
    assign unused_pred_taken = upd_pred_taken;

    always_comb begin
        valid_d    = valid_q;
        tag_d      = tag_q;
        ctr_d      = ctr_q;
        target_d   = target_q;
        flush_d    = mispredict;
        redirect_d = mispredict ? actual_npc : redirect_q;
        if (upd_valid) begin
            if (upd_hit) begin
                ctr_d[upd_idx] = upd_ctr_nxt;
                if (upd_taken)
                    target_d[upd_idx] = upd_target;
            end else if (upd_taken) begin
                // Allocate weakly taken; a not-taken miss leaves the entry alone.
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                ctr_d[upd_idx]    = CTR_ALLOC;
                target_d[upd_idx] = upd_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            for (int i = 0; i < ENTRIES; i++)
                ctr_q[i] <= CTR_INIT;
            flush_q    <= 1'b0;
            redirect_q <= '0;
`ifdef BPU_GSHARE_EN
            hist_q     <= '0;
`endif
        end else begin
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            ctr_q      <= ctr_d;
            target_q   <= target_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
`ifdef BPU_GSHARE_EN
            hist_q     <= hist_d;
`endif
        end
    end

    assign flush       = flush_q;
    assign redirect_pc = redirect_q;

endmodule
